// File: rtl/argmax_pkg.sv
`default_nettype none
// ============================================================================
// Module  : argmax_pkg
// Purpose : Shared types and helpers for the argmax_scan block.
//           - state_t   : scan controller states
//           - score_lsb : bit offset of class i inside the packed score bus
// Revision: 1.0 - initial release
// ============================================================================
package argmax_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Class i occupies scores[i*conf_w +: conf_w].
  function automatic int unsigned score_lsb(input int unsigned idx,
                                            input int unsigned conf_w);
    return idx * conf_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/argmax_cmp.sv
`default_nettype none
// ============================================================================
// Module  : argmax_cmp
// Purpose : Combinational unsigned magnitude comparator.
// Ports   : a, b  in  CONF_W  operands (unsigned)
//           gt    out 1       a > b
//           eq    out 1       a == b
// Revision: 1.0 - initial release
// ============================================================================
module argmax_cmp #(
  parameter int CONF_W = 4
) (
  input  logic [CONF_W-1:0] a,
  input  logic [CONF_W-1:0] b,
  output logic              gt,
  output logic              eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule
`default_nettype wire

// File: rtl/argmax_scan.sv
`default_nettype none
// ============================================================================
// Module  : argmax_scan
// Purpose : Snapshots NUM_CLASSES unsigned confidence scores on start, scans
//           one class per cycle and reports the index/value of the maximum
//           (lowest index wins on ties) with a busy/done handshake.
// Ports   : clk        in  1                    system clock
//           rst        in  1                    async active-high reset
//           start      in  1                    pulse: scores valid, scan
//           scores     in  NUM_CLASSES*CONF_W   class i at [i*CONF_W +: CONF_W]
//           busy       out 1                    high while scanning
//           done       out 1                    one-cycle result pulse
//           class_idx  out IDX_W                index of maximum
//           class_conf out CONF_W               maximum value
//           margin     out CONF_W               best - second best
//           low_conf   out 1                    margin < MARGIN_THRESH
// Macro   : ARGMAX_MARGIN_EN - builds the second-best tracker; when
//           undefined margin and low_conf are tied to 0.
// Revision: 1.0 - initial release
// ============================================================================
module argmax_scan
  import argmax_pkg::*;
#(
  parameter int NUM_CLASSES   = 10,
  parameter int CONF_W        = 4,
  parameter int IDX_W         = $clog2(NUM_CLASSES),
  parameter int MARGIN_THRESH = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_CLASSES*CONF_W-1:0] scores,
  output logic                          busy,
  output logic                          done,
  output logic [IDX_W-1:0]              class_idx,
  output logic [CONF_W-1:0]             class_conf,
  output logic [CONF_W-1:0]             margin,
  output logic                          low_conf
);

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CONF_W-1:0]  r_snap [NUM_CLASSES];
  logic [CONF_W-1:0]  w_slice [NUM_CLASSES];
  logic [IDX_W-1:0]   r_idx;
  logic [CONF_W-1:0]  r_best;
  logic [IDX_W-1:0]   r_best_idx;
  logic [CONF_W-1:0]  w_score;
  logic               w_last;
  logic               w_best_gt;
  logic               w_best_eq;
  logic               w_take_best;
  logic [CONF_W-1:0]  w_best_nxt;
  logic [IDX_W-1:0]   w_best_idx_nxt;

  // Unpack the score bus into per-class slices.
  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_slice
    assign w_slice[g] = scores[score_lsb(g, CONF_W) +: CONF_W];
  end

  assign w_score = r_snap[r_idx];
  assign w_last  = (r_idx == c_LAST_IDX);
  assign busy    = (r_state == SCAN);
  assign done    = (r_state == DONE);

  argmax_cmp #(.CONF_W(CONF_W)) u_cmp_best (
    .a  (w_score),
    .b  (r_best),
    .gt (w_best_gt),
    .eq (w_best_eq)
  );

  // Only a strictly greater score displaces the incumbent, so the earliest
  // index holding the maximum survives.
  assign w_take_best    = w_best_gt & ~w_best_eq;
  assign w_best_nxt     = w_take_best ? w_score : r_best;
  assign w_best_idx_nxt = w_take_best ? r_idx   : r_best_idx;

`ifdef ARGMAX_MARGIN_EN
  localparam logic [CONF_W-1:0] c_THRESH = CONF_W'(MARGIN_THRESH);

  logic [CONF_W-1:0] r_second;
  logic [CONF_W-1:0] w_second_nxt;
  logic [CONF_W-1:0] w_margin_nxt;
  logic              w_sec_gt;
  logic              w_sec_eq;

  argmax_cmp #(.CONF_W(CONF_W)) u_cmp_second (
    .a  (w_score),
    .b  (r_second),
    .gt (w_sec_gt),
    .eq (w_sec_eq)
  );

  // A new best demotes the old best; otherwise a score tying the best still
  // lands in second, which is what drives the margin to 0 on ties.
  assign w_second_nxt = w_take_best            ? r_best  :
                        (w_sec_gt & ~w_sec_eq) ? w_score : r_second;
  assign w_margin_nxt = w_best_nxt - w_second_nxt;
`else
  assign margin   = '0;
  assign low_conf = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = SCAN;
      SCAN:    if (start) w_state_nxt = SCAN;
               else if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? SCAN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // start has priority in every state: it re-snapshots and restarts, which
  // also suppresses the result of a scan still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap     <= '{default: '0};
      r_idx      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      class_idx  <= '0;
      class_conf <= '0;
`ifdef ARGMAX_MARGIN_EN
      r_second   <= '0;
      margin     <= '0;
      low_conf   <= 1'b0;
`endif
    end else if (start) begin
      r_snap     <= w_slice;
      r_idx      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
`ifdef ARGMAX_MARGIN_EN
      r_second   <= '0;
`endif
    end else if (r_state == SCAN) begin
      r_best     <= w_best_nxt;
      r_best_idx <= w_best_idx_nxt;
      r_idx      <= w_last ? r_idx : r_idx + IDX_W'(1);
`ifdef ARGMAX_MARGIN_EN
      r_second   <= w_second_nxt;
`endif
      // Publish on the final comparison edge so results are valid exactly
      // in the DONE cycle and never expose partial scan values.
      if (w_last) begin
        class_idx  <= w_best_idx_nxt;
        class_conf <= w_best_nxt;
`ifdef ARGMAX_MARGIN_EN
        margin     <= w_margin_nxt;
        low_conf   <= (w_margin_nxt < c_THRESH);
`endif
      end
    end
  end

endmodule
`default_nettype wire
